md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  Multiply/divide unit in EX stage; consumes start/mdctr/hiwrite/lowrite from the pipeline controller
//  and returns busy to its hazard monitor. Holds HI/LO; result read combinationally by the EX-stage mux.
//  Multi-cycle: busy stalls any following MD-class instruction in D until the result is committed.
// PARAMETERS
//  MULT_CYCLES  5   cycles busy is high for mult/multu (>=1)
//  DIV_CYCLES   10  cycles busy is high for div/divu (>=1)
// PORTS
//  clk      in   1   clock, rising edge
//  rst      in   1   asynchronous, active-low reset
//  start    in   1   launch op in mdctr this cycle (one-cycle pulse)
//  mdctr    in   3   op: 0 mult, 1 multu, 2 div, 3 divu, 4 madd, 5 maddu, others no-op
//  a        in   32  operand rs (forwarded); also mthi/mtlo data
//  b        in   32  operand rt (forwarded)
//  hiwrite  in   1   mthi: HI <= a
//  lowrite  in   1   mtlo: LO <= a
//  busy     out  1   operation in flight
//  hi       out  32  HI register
//  lo       out  32  LO register
// BEHAVIOUR
//  Reset (rst=0, async): busy=0, hi=0, lo=0, counter=0, state IDLE, latched operands/result cleared.
//  States: IDLE, RUN. IDLE--start & valid op-->RUN; RUN--counter==1-->IDLE.
//  Edge with start=1 in IDLE: latch a, b, mdctr; compute result into internal regs; counter <= N
//   (N=MULT_CYCLES for mult/multu/madd/maddu, DIV_CYCLES for div/divu); busy=1 from next cycle.
//  busy is high exactly N cycles; on edge where counter==1: hi/lo <= latched result, busy<=0.
//   hi/lo unchanged while busy; new values visible the cycle busy falls.
//  start with invalid mdctr (6,7): ignored, busy stays 0.
//  mult:  {hi,lo} = signed(a)*signed(b), 64-bit.  multu: unsigned 64-bit product.
//  div:   lo = signed quotient truncated toward zero, hi = remainder with sign of dividend.
//  divu:  unsigned quotient/remainder.
//  div/divu with b==0: busy still asserted DIV_CYCLES; hi/lo retain prior values on completion.
//  div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
//  hiwrite/lowrite: take effect on the edge they are sampled, only when not busy and start=0;
//   if asserted while busy or with start: ignored (controller never issues it; bench checks no corruption).
//  start while busy: ignored; in-flight op unaffected.
//  hiwrite & lowrite together: both written with a.
//  No cancel input: an op launched before an interrupt flush completes and commits (MIPS HI/LO semantics).
//  Reset mid-operation: op discarded, all outputs return to reset values immediately.
//  Outputs registered; no combinational path from inputs to busy/hi/lo.
// CONFIGURATION
//  MD_MADD_EN defined: mdctr 4 madd {hi,lo} <= {hi,lo} + signed(a)*signed(b); 5 maddu unsigned;
//   accumulation uses hi/lo sampled at start edge, mod 2^64; latency MULT_CYCLES.
//  MD_MADD_EN undefined: mdctr 4,5 treated as invalid (ignored, busy stays 0); no accumulator logic.
// TESTING
//  Reset: rst=0 mid-mult -> busy=0, hi=lo=0 asynchronously; no commit after rst=1.
//  mult a=0xFFFFFFFE b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF lo=0xFFFFFFFA; multu same -> hi=2 lo=0xFFFFFFFA.
//  div a=-7 b=2 -> busy 10 cycles; lo=0xFFFFFFFD hi=0xFFFFFFFF; divu a=7 b=2 -> lo=3 hi=1.
//  div by zero with hi=0x11 lo=0x22 preset via mthi/mtlo -> busy 10 cycles, hi=0x11 lo=0x22 after.
//  mthi a=0xABCD while busy, and start during busy -> ignored; in-flight result commits unchanged.
//  MD_MADD_EN: hi=0 lo=0xFFFFFFFF, madd a=1 b=1 -> hi=1 lo=0; without macro mdctr=4 -> busy never rises.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit that owns the HI/LO registers.
// Ports: clk, rst (async, active low), start, mdctr, a, b, hiwrite, lowrite -> busy, hi, lo.
// Parameters: MULT_CYCLES (busy length for mult/multu/madd/maddu) and DIV_CYCLES (busy length for div/divu).
// Optional feature: define MD_MADD_EN to enable madd (mdctr 4) and maddu (mdctr 5).
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  mdctr,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hiwrite,
    input  logic        lowrite,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] MUL_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] ONE   = CW'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;
    logic          res_wr;

    logic          valid_op;
    logic          start_ok;
    logic [63:0]   prod_s;
    logic [63:0]   prod_u;
    logic          a_neg;
    logic          b_neg;
    logic [31:0]   mag_a;
    logic [31:0]   mag_b;
    logic [31:0]   uq;
    logic [31:0]   ur;
    logic [31:0]   q;
    logic [31:0]   r;
    logic [31:0]   nxt_hi;
    logic [31:0]   nxt_lo;
    logic          nxt_wr;
    logic [CW-1:0] nxt_n;

    always_comb begin
        valid_op = 1'b0;
        case (mdctr)
            3'd0, 3'd1, 3'd2, 3'd3: valid_op = 1'b1;
`ifdef MD_MADD_EN
            3'd4, 3'd5:             valid_op = 1'b1;
`endif
            default:                valid_op = 1'b0;
        endcase
    end

    assign start_ok = start & valid_op & (state == IDLE);

    // Sign-extended operands make the low 64 bits of the product the signed result.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide via magnitudes: avoids simulator-specific handling of
    // 0x80000000 / -1, which then naturally yields q=0x80000000, r=0.
    assign a_neg = (mdctr == 3'd2) & a[31];
    assign b_neg = (mdctr == 3'd2) & b[31];
    assign mag_a = a_neg ? (32'd0 - a) : a;
    assign mag_b = b_neg ? (32'd0 - b) : b;
    assign uq    = (mag_b == 32'd0) ? 32'd0 : mag_a / mag_b;
    assign ur    = (mag_b == 32'd0) ? 32'd0 : mag_a % mag_b;
    assign q     = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
    assign r     = a_neg ? (32'd0 - ur) : ur;

    always_comb begin
        nxt_hi = hi;
        nxt_lo = lo;
        nxt_wr = 1'b0;
        nxt_n  = MUL_N;
        case (mdctr)
            3'd0: begin
                {nxt_hi, nxt_lo} = prod_s;
                nxt_wr = 1'b1;
            end
            3'd1: begin
                {nxt_hi, nxt_lo} = prod_u;
                nxt_wr = 1'b1;
            end
            3'd2, 3'd3: begin
                nxt_hi = r;
                nxt_lo = q;
                nxt_wr = (b != 32'd0);
                nxt_n  = DIV_N;
            end
`ifdef MD_MADD_EN
            3'd4: begin
                {nxt_hi, nxt_lo} = {hi, lo} + prod_s;
                nxt_wr = 1'b1;
            end
            3'd5: begin
                {nxt_hi, nxt_lo} = {hi, lo} + prod_u;
                nxt_wr = 1'b1;
            end
`endif
            default: nxt_wr = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = RUN;
            RUN:     if (cnt == ONE) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            res_hi <= '0;
            res_lo <= '0;
            res_wr <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (start_ok) begin
            cnt    <= nxt_n;
            res_hi <= nxt_hi;
            res_lo <= nxt_lo;
            res_wr <= nxt_wr;
        end else if (state == RUN) begin
            cnt <= cnt - ONE;
            if (cnt == ONE && res_wr) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end else if (!start) begin
            if (hiwrite) hi <= a;
            if (lowrite) lo <= a;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed-vector bench for md_unit.
// Covers reset, mult/multu/div/divu, divide by zero and overflow, busy-time disturbances, mthi/mtlo, madd gating.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  mdctr = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        hiwrite = 1'b0;
    logic        lowrite = 1'b0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int nchk = 0;
    int nerr = 0;
    int n;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst(rst), .start(start), .mdctr(mdctr),
        .a(a), .b(b), .hiwrite(hiwrite), .lowrite(lowrite),
        .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic op(input logic [2:0] c, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        start = 1'b1; mdctr = c; a = va; b = vb;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic mt(input logic wh, input logic wl, input logic [31:0] v);
        @(negedge clk);
        hiwrite = wh; lowrite = wl; a = v;
        @(negedge clk);
        hiwrite = 1'b0; lowrite = 1'b0;
    endtask

    initial begin
        #3;
        check("rst_busy", busy, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        @(negedge clk);
        rst = 1'b1;

        op(3'd0, 32'hFFFFFFFE, 32'd3);
        wait_idle(n);
        check("mult_cyc", n, 5);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFA);

        op(3'd1, 32'hFFFFFFFE, 32'd3);
        wait_idle(n);
        check("multu_cyc", n, 5);
        check("multu_hi", hi, 32'h2);
        check("multu_lo", lo, 32'hFFFFFFFA);

        op(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_idle(n);
        check("div_cyc", n, 10);
        check("div_hi", hi, 32'hFFFFFFFF);
        check("div_lo", lo, 32'hFFFFFFFD);

        op(3'd3, 32'd7, 32'd2);
        wait_idle(n);
        check("divu_cyc", n, 10);
        check("divu_hi", hi, 32'h1);
        check("divu_lo", lo, 32'h3);

        mt(1'b1, 1'b0, 32'h11);
        mt(1'b0, 1'b1, 32'h22);
        check("mthi", hi, 32'h11);
        check("mtlo", lo, 32'h22);
        op(3'd2, 32'd100, 32'd0);
        wait_idle(n);
        check("div0_cyc", n, 10);
        check("div0_hi", hi, 32'h11);
        check("div0_lo", lo, 32'h22);

        op(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n);
        check("ovf_hi", hi, 32'h0);
        check("ovf_lo", lo, 32'h80000000);

        op(3'd0, 32'h1234, 32'h10);
        check("inflt_busy", busy, 1);
        hiwrite = 1'b1; lowrite = 1'b1; a = 32'hABCD;
        start = 1'b1; mdctr = 3'd2; b = 32'd0;
        @(negedge clk);
        hiwrite = 1'b0; lowrite = 1'b0; start = 1'b0;
        check("inflt_hi", hi, 32'h0);
        check("inflt_lo", lo, 32'h80000000);
        wait_idle(n);
        check("inflt_cyc", n, 4);
        check("inflt_rhi", hi, 32'h0);
        check("inflt_rlo", lo, 32'h12340);
        @(negedge clk);
        check("inflt_idle", busy, 0);

        mt(1'b1, 1'b1, 32'h5A5A);
        check("mtboth_hi", hi, 32'h5A5A);
        check("mtboth_lo", lo, 32'h5A5A);

        op(3'd6, 32'd1, 32'd1);
        check("inv6_busy", busy, 0);
        op(3'd7, 32'd1, 32'd1);
        check("inv7_busy", busy, 0);
        check("inv_hi", hi, 32'h5A5A);
        check("inv_lo", lo, 32'h5A5A);

`ifdef MD_MADD_EN
        mt(1'b1, 1'b0, 32'h0);
        mt(1'b0, 1'b1, 32'hFFFFFFFF);
        op(3'd4, 32'd1, 32'd1);
        wait_idle(n);
        check("madd_cyc", n, 5);
        check("madd_hi", hi, 32'h1);
        check("madd_lo", lo, 32'h0);
`else
        op(3'd4, 32'd1, 32'd1);
        check("madd_off_busy", busy, 0);
        op(3'd5, 32'd1, 32'd1);
        check("maddu_off_busy", busy, 0);
        repeat (6) @(negedge clk);
        check("madd_off_hi", hi, 32'h5A5A);
        check("madd_off_lo", lo, 32'h5A5A);
`endif

        mt(1'b1, 1'b1, 32'h77);
        op(3'd0, 32'd3, 32'd5);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check("post_busy", busy, 0);
        check("post_hi", hi, 0);
        check("post_lo", lo, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
